// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
// Definitions shared by the fetch-side PC / prediction-tracking pipeline.
//   - branch_e_t   : redirect code returned to NPC_Generator from stage E
//   - FLAG_HIT/FLAG_PRED : bit positions inside the 2-bit BTB flag field
//   - IDX_W_DEFAULT / CNT_W_DEFAULT : default BTB index and counter widths
// ---------------------------------------------------------------------------
package bp_pkg;

   localparam int IDX_W_DEFAULT = 3;    // 8-entry BTB
   localparam int CNT_W_DEFAULT = 32;

   localparam int FLAG_HIT  = 0;
   localparam int FLAG_PRED = 1;

   typedef enum logic [1:0] {
      BR_OK             = 2'b00,   // prediction correct, no redirect
      BR_MISS_TAKEN     = 2'b01,   // BTB miss, branch actually taken
      BR_HIT_NT_TAKEN   = 2'b10,   // BTB hit predicted not-taken, actually taken
      BR_HIT_T_NOTTAKEN = 2'b11    // predicted taken, not taken (or not a branch)
   } branch_e_t;

   // Resolve one branch against its prediction. A flag value of 2'b10
   // (predict taken without a hit) cannot come from a sane BTB; since the
   // hit bit is clear it falls through to the miss path, i.e. it behaves
   // exactly like 2'b00.
   function automatic branch_e_t classify_branch(
      input logic [1:0] flags,
      input logic       is_branch,
      input logic       taken
   );
      branch_e_t code;
      code = BR_OK;
      if (flags[FLAG_HIT] && flags[FLAG_PRED]) begin
         // A predicted-taken redirect already happened; undo it whenever
         // the instruction turned out not to be a taken branch.
         if (!is_branch || !taken) begin
            code = BR_HIT_T_NOTTAKEN;
         end
      end else if (flags[FLAG_HIT]) begin
         if (is_branch && taken) begin
            code = BR_HIT_NT_TAKEN;
         end
      end else begin
         if (is_branch && taken) begin
            code = BR_MISS_TAKEN;
         end
      end
      return code;
   endfunction

endpackage

// File: rtl/bp_stage_reg.sv
// ---------------------------------------------------------------------------
// bp_stage_reg
// One pipeline stage register carrying a PC, its BTB flags and BTB index.
// Priority: srst > flush > stall > load.
// Ports:
//   clk, srst              : clock, synchronous active-high reset
//   stall                  : hold current contents
//   flush                  : clear contents to a bubble (all zero)
//   next_pc/next_flags/next_index : values loaded when not stalled
//   pc/flags/index         : registered stage contents
// ---------------------------------------------------------------------------
module bp_stage_reg
   import bp_pkg::*;
#(
   parameter int IDX_W = IDX_W_DEFAULT
)(
   input  logic             clk,
   input  logic             srst,
   input  logic             stall,
   input  logic             flush,
   input  logic [31:0]      next_pc,
   input  logic [1:0]       next_flags,
   input  logic [IDX_W-1:0] next_index,
   output logic [31:0]      pc,
   output logic [1:0]       flags,
   output logic [IDX_W-1:0] index
);

   logic [31:0]      pc_reg;
   logic [1:0]       flags_reg;
   logic [IDX_W-1:0] index_reg;

   always_ff @(posedge clk) begin
      if (srst || flush) begin
         pc_reg    <= '0;
         flags_reg <= '0;
         index_reg <= '0;
      end else if (!stall) begin
         pc_reg    <= next_pc;
         flags_reg <= next_flags;
         index_reg <= next_index;
      end
   end

   assign pc    = pc_reg;
   assign flags = flags_reg;
   assign index = index_reg;

endmodule

// File: rtl/bp_pipe_track.sv
// ---------------------------------------------------------------------------
// bp_pipe_track
// Fetch-side PC register plus F->D->E tracking of BTB hit/prediction flags
// and BTB index. In E the resolved branch is compared to the prediction and
// a 2-bit redirect code (BranchE) is returned combinationally to
// NPC_Generator. Branch and misprediction counters are kept for statistics.
// Ports:
//   clk, CpuRst                  : clock, synchronous active-high reset
//   PC_In, BranchFlags, BranchIndex : next PC and its BTB lookup result
//   StallF/D/E, FlushD/E         : hazard-unit controls per stage
//   IsBranchE, BranchTakenE      : branch resolution for the E instruction
//   PCF/PCD/PCE                  : per-stage PC
//   BranchFlagsF/E, BranchIndexF/E : per-stage prediction info
//   BranchE                      : redirect code (00 = no redirect)
//   BrCount, MissCount           : saturating statistics counters
// ---------------------------------------------------------------------------
module bp_pipe_track
   import bp_pkg::*;
#(
   parameter int IDX_W = IDX_W_DEFAULT,
   parameter int CNT_W = CNT_W_DEFAULT
)(
   input  logic             clk,
   input  logic             CpuRst,
   input  logic [31:0]      PC_In,
   input  logic [1:0]       BranchFlags,
   input  logic [IDX_W-1:0] BranchIndex,
   input  logic             StallF,
   input  logic             StallD,
   input  logic             StallE,
   input  logic             FlushD,
   input  logic             FlushE,
   input  logic             IsBranchE,
   input  logic             BranchTakenE,
   output logic [31:0]      PCF,
   output logic [31:0]      PCD,
   output logic [31:0]      PCE,
   output logic [1:0]       BranchFlagsF,
   output logic [1:0]       BranchFlagsE,
   output logic [IDX_W-1:0] BranchIndexF,
   output logic [IDX_W-1:0] BranchIndexE,
   output logic [1:0]       BranchE,
   output logic [CNT_W-1:0] BrCount,
   output logic [CNT_W-1:0] MissCount
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // D-stage prediction info is internal only; it just feeds stage E.
   logic [1:0]       flags_d;
   logic [IDX_W-1:0] index_d;

   // ------------------------------------------------------------------
   // Stage registers. F never bubbles, so its flush is tied off.
   // ------------------------------------------------------------------
   bp_stage_reg #(.IDX_W(IDX_W)) u_stage_f (
      .clk        (clk),
      .srst       (CpuRst),
      .stall      (StallF),
      .flush      (1'b0),
      .next_pc    (PC_In),
      .next_flags (BranchFlags),
      .next_index (BranchIndex),
      .pc         (PCF),
      .flags      (BranchFlagsF),
      .index      (BranchIndexF)
   );

   bp_stage_reg #(.IDX_W(IDX_W)) u_stage_d (
      .clk        (clk),
      .srst       (CpuRst),
      .stall      (StallD),
      .flush      (FlushD),
      .next_pc    (PCF),
      .next_flags (BranchFlagsF),
      .next_index (BranchIndexF),
      .pc         (PCD),
      .flags      (flags_d),
      .index      (index_d)
   );

   bp_stage_reg #(.IDX_W(IDX_W)) u_stage_e (
      .clk        (clk),
      .srst       (CpuRst),
      .stall      (StallE),
      .flush      (FlushE),
      .next_pc    (PCD),
      .next_flags (flags_d),
      .next_index (index_d),
      .pc         (PCE),
      .flags      (BranchFlagsE),
      .index      (BranchIndexE)
   );

   // ------------------------------------------------------------------
   // Classification: purely combinational from E state so NPC_Generator
   // can redirect in the same cycle.
   // ------------------------------------------------------------------
   branch_e_t br_class;

   always_comb begin
      br_class = classify_branch(BranchFlagsE, IsBranchE, BranchTakenE);
   end

   assign BranchE = br_class;

   // ------------------------------------------------------------------
   // Statistics. Counting only on non-stalled cycles means an instruction
   // held in E by a stall contributes exactly once, on the cycle it leaves.
   // ------------------------------------------------------------------
   logic [CNT_W-1:0] br_count_reg;
   logic [CNT_W-1:0] miss_count_reg;
   logic [CNT_W-1:0] br_count_next;
   logic [CNT_W-1:0] miss_count_next;

   always_comb begin
      br_count_next   = br_count_reg;
      miss_count_next = miss_count_reg;
      if (!StallE) begin
         if (IsBranchE && (br_count_reg != CNT_MAX)) begin
            br_count_next = br_count_reg + CNT_W'(1);
         end
         if ((br_class != BR_OK) && (miss_count_reg != CNT_MAX)) begin
            miss_count_next = miss_count_reg + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (CpuRst) begin
         br_count_reg   <= '0;
         miss_count_reg <= '0;
      end else begin
         br_count_reg   <= br_count_next;
         miss_count_reg <= miss_count_next;
      end
   end

   assign BrCount   = br_count_reg;
   assign MissCount = miss_count_reg;

endmodule

// File: doc/bp_pipe_track.md
# bp_pipe_track

Fetch-side PC register and prediction-tracking pipeline for the RISC-V pipeline CPU. It sits directly downstream of NPC_Generator: it latches PC_In into PCF and carries the BTB hit/prediction flags and BTB index from F through D to E. In E it classifies the resolved branch against the prediction and drives the 2-bit BranchE code back to NPC_Generator. It also keeps branch and misprediction counters for lab statistics.

## Interface
Parameters:
- IDX_W, 3, BTB index width (8 entries)
- CNT_W, 32, statistics counter width

Ports:
- clk  in  1  clock; all state updates on posedge
- CpuRst  in  1  synchronous, active-high reset
- PC_In  in  32  next PC from NPC_Generator
- BranchFlags  in  2  [0]=BTB hit, [1]=predict taken, for PC_In
- BranchIndex  in  IDX_W  BTB entry matching PC_In
- StallF, StallD, StallE  in  1 each  hold the F / D / E stage registers
- FlushD, FlushE  in  1 each  bubble the D / E stage registers
- IsBranchE  in  1  conditional branch instruction in E
- BranchTakenE  in  1  resolved branch outcome in E
- PCF, PCD, PCE  out  32  per-stage PC
- BranchFlagsF, BranchFlagsE  out  2  per-stage flags
- BranchIndexF, BranchIndexE  out  IDX_W  per-stage BTB index
- BranchE  out  2  classification, combinational from E state
- BrCount, MissCount  out  CNT_W  branches retired from E / mispredicts

## Operation
- F register (PCF, BranchFlagsF, BranchIndexF):
  - loads PC_In/BranchFlags/BranchIndex when !StallF
  - holds when StallF
- D register (PCD plus flags/index):
  - FlushD clears all fields to 0
  - else when !StallD, copies the F fields
  - else holds
- E register (PCE, BranchFlagsE, BranchIndexE, plus internal flags for D):
  - FlushE clears all fields to 0
  - else when !StallE, copies the D fields
  - else holds
- Flush has priority over stall in every stage. CpuRst has priority over everything.
- BranchE classification:
  - 00: no redirect. Either not a branch and flags != 11, or the prediction was correct (hit and taken==predicted, or miss and not taken).
  - 01: IsBranchE, BTB miss (flags[0]=0), BranchTakenE=1.
  - 10: IsBranchE, hit, predicted not-taken (flags=01), BranchTakenE=1.
  - 11: hit and predicted taken (flags=11), and either BranchTakenE=0 or !IsBranchE (stale/aliased entry). NPC_Generator then refetches from PCE+4.
- Flags value 10 (taken without hit) is illegal. It is treated as 00 and flagged by a bench assertion.
- Counters advance only on cycles with !StallE and !CpuRst, so a stalled instruction is counted once:
  - BrCount += 1 when IsBranchE
  - MissCount += 1 when BranchE != 00
- Both counters saturate at all-ones and do not wrap.

## Timing
- Reset values: PCF = 0, every flag/index/PC register = 0, BrCount = MissCount = 0, hence BranchE = 00.
- Reset is synchronous. CpuRst asserted mid-stream clears all state at the next edge, regardless of stall or flush.
- PC_In to PCF: 1 cycle. PCF to PCD: 1 cycle. PCD to PCE: 1 cycle, absent stalls.
- BranchE is valid in the same cycle the E register holds the instruction, with zero added latency. NPC_Generator consumes it that cycle.
- The hazard unit asserts FlushD and FlushE on the cycle BranchE != 00. The next edge bubbles D and E. F loads the corrected PC_In on that same edge.
- When StallE holds a mispredicted branch, BranchE stays asserted every held cycle and MissCount increments once.

## Structure
- Shared package bp_pkg holds:
  - BranchE codes: BR_OK=2'b00, BR_MISS_TAKEN=2'b01, BR_HIT_NT_TAKEN=2'b10, BR_HIT_T_NOTTAKEN=2'b11
  - flag bit positions: FLAG_HIT=0, FLAG_PRED=1
  - IDX_W default
- Sub-module bp_stage_reg holds PC, flags and index with stall/flush/reset. It is instantiated for D and E; F uses it with flush tied 0.
- Classification and counters stay in the top module.

## Test plan
- Reset: hold CpuRst 2 cycles with PC_In=0x40 -> all outputs 0; the first edge after release gives PCF=0x40.
- Flow: PC_In 0x00,0x04,0x08 with flags 00 and no stalls -> PCE=0x00 on the 3rd edge, BranchFlagsE=00, BranchE=00.
- BTB miss taken: E holds PCE=0x10, flags 00, IsBranchE=1, BranchTakenE=1 -> BranchE=01, MissCount 0→1, BrCount 0→1.
- Predicted-taken wrong: flags 11, index 5, IsBranchE=1, BranchTakenE=0 -> BranchE=11, BranchIndexE=5. Then FlushD/FlushE -> next edge PCD=PCE=0, flags 0.
- StallE for 3 cycles on a mispredicted (flags 01, taken) branch -> BranchE=10 held all 3 cycles, MissCount +1 only, BrCount +1 only.
- Saturation and priority:
  - preload MissCount=all-ones, then mispredict -> MissCount stays all-ones
  - FlushE and StallE together -> E cleared
  - CpuRst and StallF together -> PCF=0
